// File: rtl/prg_ram_loader.sv
// PRG loader: turns an ioctl PRG download into RAM port-A writes, then patches the end-of-program pointers.
// Optional macro PRG_AUTORUN_EN also types "RUN<CR>" into the keyboard buffer before finishing.
module prg_ram_loader #(
   parameter logic [7:0] PRG_INDEX = 8'd1,
   parameter int         PATCH_GAP = 1
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [15:0] dl_addr,
   output logic [7:0]  dl_data,
   output logic        dl_wr,
   output logic        busy,
   output logic        load_done,
   output logic        err_short
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      HDR     = 3'd1,
      DATA    = 3'd2,
      PATCH   = 3'd3,
`ifdef PRG_AUTORUN_EN
      AUTORUN = 3'd4,
`endif
      DONE    = 3'd5
   } state_t;

   localparam logic [3:0] PATCH_LAST   = 4'd7;
`ifdef PRG_AUTORUN_EN
   localparam logic [3:0] AUTORUN_LAST = 4'd12;
`endif
   localparam logic [7:0] GAP_INIT     = 8'(PATCH_GAP);

   // Steps 0..7 are the pointer patch pairs, 8..12 the autorun keystrokes.
   function automatic logic [15:0] seq_addr(input logic [3:0] step);
      case (step)
         4'd0:    seq_addr = 16'h002D;
         4'd1:    seq_addr = 16'h002E;
         4'd2:    seq_addr = 16'h002F;
         4'd3:    seq_addr = 16'h0030;
         4'd4:    seq_addr = 16'h0031;
         4'd5:    seq_addr = 16'h0032;
         4'd6:    seq_addr = 16'h00AE;
         4'd7:    seq_addr = 16'h00AF;
         4'd8:    seq_addr = 16'h0527;
         4'd9:    seq_addr = 16'h0528;
         4'd10:   seq_addr = 16'h0529;
         4'd11:   seq_addr = 16'h052A;
         default: seq_addr = 16'h00EF;
      endcase
   endfunction

   function automatic logic [7:0] seq_data(input logic [3:0] step, input logic [15:0] end_addr);
      if (!step[3]) begin
         seq_data = step[0] ? end_addr[15:8] : end_addr[7:0];
      end else begin
         case (step)
            4'd8:    seq_data = 8'h52;
            4'd9:    seq_data = 8'h55;
            4'd10:   seq_data = 8'h4E;
            4'd11:   seq_data = 8'h0D;
            default: seq_data = 8'h04;
         endcase
      end
   endfunction

   state_t      state_reg, state_next;
   logic [15:0] addr_reg, addr_next;
   logic [15:0] dl_addr_reg, dl_addr_next;
   logic [7:0]  dl_data_reg, dl_data_next;
   logic        dl_wr_reg, dl_wr_next;
   logic        busy_reg, busy_next;
   logic        load_done_reg, load_done_next;
   logic        err_short_reg, err_short_next;
   logic [3:0]  step_reg, step_next;
   logic [7:0]  gap_reg, gap_next;
   logic        payload_reg, payload_next;
   logic        dl_prev_reg;

   logic        qual_idx, dl_act, dl_fall, start_wr, data_hit;
   logic        hdr_wr, emit_seq;
   logic [3:0]  emit_step;

   assign qual_idx = (ioctl_index == PRG_INDEX);
   assign dl_act   = ioctl_download && qual_idx;
   assign dl_fall  = dl_prev_reg && !dl_act;
   assign start_wr = ioctl_wr && dl_act;
   // A byte strobed on the same cycle the window closes still belongs to the file.
   assign data_hit = ioctl_wr && qual_idx && (ioctl_download || dl_prev_reg) && (ioctl_addr >= 25'd2);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg     <= IDLE;
         addr_reg      <= 16'd0;
         dl_addr_reg   <= 16'd0;
         dl_data_reg   <= 8'd0;
         dl_wr_reg     <= 1'b0;
         busy_reg      <= 1'b0;
         load_done_reg <= 1'b0;
         err_short_reg <= 1'b0;
         step_reg      <= 4'd0;
         gap_reg       <= 8'd0;
         payload_reg   <= 1'b0;
         dl_prev_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         dl_addr_reg   <= dl_addr_next;
         dl_data_reg   <= dl_data_next;
         dl_wr_reg     <= dl_wr_next;
         busy_reg      <= busy_next;
         load_done_reg <= load_done_next;
         err_short_reg <= err_short_next;
         step_reg      <= step_next;
         gap_reg       <= gap_next;
         payload_reg   <= payload_next;
         dl_prev_reg   <= dl_act;
      end
   end

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      dl_addr_next   = dl_addr_reg;
      dl_data_next   = dl_data_reg;
      dl_wr_next     = 1'b0;
      busy_next      = busy_reg;
      load_done_next = 1'b0;
      err_short_next = err_short_reg;
      step_next      = step_reg;
      gap_next       = gap_reg;
      payload_next   = payload_reg;
      hdr_wr         = 1'b0;
      emit_seq       = 1'b0;
      emit_step      = 4'd0;

      case (state_reg)
         IDLE: hdr_wr = start_wr;

         HDR: begin
            if (dl_fall) begin
               state_next     = IDLE;
               busy_next      = 1'b0;
               err_short_next = 1'b1;
            end else begin
               hdr_wr = start_wr;
            end
         end

         DATA: begin
            if (data_hit) begin
               dl_wr_next   = 1'b1;
               dl_addr_next = addr_reg;
               dl_data_next = ioctl_dout;
               addr_next    = addr_reg + 16'd1;
               payload_next = 1'b1;
            end
            if (dl_fall) begin
               if (payload_reg || data_hit) begin
                  state_next = PATCH;
                  step_next  = 4'd0;
                  gap_next   = GAP_INIT;
                  // Without a final byte this cycle the first patch write goes out right away.
                  emit_seq   = !data_hit;
               end else begin
                  state_next     = IDLE;
                  busy_next      = 1'b0;
                  err_short_next = 1'b1;
               end
            end
         end

         PATCH: begin
            if (start_wr) begin
               hdr_wr = 1'b1;
            end else if (gap_reg != 8'd0) begin
               gap_next = gap_reg - 8'd1;
            end else begin
               emit_seq  = 1'b1;
               emit_step = step_reg;
               if (step_reg == PATCH_LAST) begin
`ifdef PRG_AUTORUN_EN
                  state_next = AUTORUN;
`else
                  state_next = DONE;
`endif
               end
            end
         end

`ifdef PRG_AUTORUN_EN
         AUTORUN: begin
            if (start_wr) begin
               hdr_wr = 1'b1;
            end else if (gap_reg != 8'd0) begin
               gap_next = gap_reg - 8'd1;
            end else begin
               emit_seq  = 1'b1;
               emit_step = step_reg;
               if (step_reg == AUTORUN_LAST) begin
                  state_next = DONE;
               end
            end
         end
`endif

         DONE: begin
            if (start_wr) begin
               hdr_wr = 1'b1;
            end else begin
               load_done_next = 1'b1;
               busy_next      = 1'b0;
               state_next     = IDLE;
            end
         end

         default: state_next = IDLE;
      endcase

      if (emit_seq) begin
         dl_wr_next   = 1'b1;
         dl_addr_next = seq_addr(emit_step);
         dl_data_next = seq_data(emit_step, addr_reg);
         step_next    = emit_step + 4'd1;
         gap_next     = GAP_INIT;
      end

      // Header bytes (including a restart byte that cuts a patch short) only load the address.
      if (hdr_wr) begin
         state_next     = HDR;
         busy_next      = 1'b1;
         err_short_next = 1'b0;
         payload_next   = 1'b0;
         if (ioctl_addr == 25'd0) begin
            addr_next[7:0] = ioctl_dout;
         end else if (ioctl_addr == 25'd1) begin
            addr_next[15:8] = ioctl_dout;
            state_next      = DATA;
         end
      end
   end

   assign dl_addr   = dl_addr_reg;
   assign dl_data   = dl_data_reg;
   assign dl_wr     = dl_wr_reg;
   assign busy      = busy_reg;
   assign load_done = load_done_reg;
   assign err_short = err_short_reg;

endmodule

// File: tb/tb_prg_ram_loader.sv
// Bench for prg_ram_loader: a table of PRG downloads plus timed corner sequences,
// checked against a cycle-stamped scoreboard of RAM writes and load_done pulses.
`timescale 1ns/1ps
module tb_prg_ram_loader;
   localparam int GAP  = 1;
   localparam int STEP = GAP + 1;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = 25'd0;
   logic [7:0]  ioctl_dout = 8'd0;
   logic [15:0] dl_addr;
   logic [7:0]  dl_data;
   logic        dl_wr;
   logic        busy;
   logic        load_done;
   logic        err_short;

   always #5 clk_sys = ~clk_sys;

   prg_ram_loader #(.PRG_INDEX(8'd1), .PATCH_GAP(GAP)) dut (
      .clk_sys(clk_sys),
      .reset(reset),
      .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout),
      .dl_addr(dl_addr),
      .dl_data(dl_data),
      .dl_wr(dl_wr),
      .busy(busy),
      .load_done(load_done),
      .err_short(err_short)
   );

   typedef struct packed {
      int          cyc;
      logic [15:0] a;
      logic [7:0]  d;
   } ev_t;

   typedef struct packed {
      logic [7:0]  idx;
      logic [3:0]  len;
      logic [79:0] bytes;     // file bytes, first byte in the top octet
      logic [15:0] end_addr;
      logic        exp_err;
      logic        exp_done;
   } vec_t;

   ev_t exp_q[$];
   ev_t obs_q[$];
   int  exp_done_q[$];
   int  obs_done_q[$];
   int  cyc = 0;
   int  total = 0;
   int  bad = 0;
   ev_t mon_e;

   always @(posedge clk_sys) cyc <= cyc + 1;

   always @(negedge clk_sys) begin
      if (dl_wr) begin
         mon_e.cyc = cyc;
         mon_e.a   = dl_addr;
         mon_e.d   = dl_data;
         obs_q.push_back(mon_e);
      end
      if (load_done) obs_done_q.push_back(cyc);
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h, want %0h", name, act, want);
      end
   endtask

   task automatic push_wr(input int c, input logic [15:0] a, input logic [7:0] d);
      ev_t e;
      e.cyc = c;
      e.a   = a;
      e.d   = d;
      exp_q.push_back(e);
   endtask

   task automatic byte_io(input int off, input logic [7:0] d, input bit exp_wr, input logic [15:0] exp_a);
      tick();
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(off);
      ioctl_dout = d;
      if (exp_wr) push_wr(cyc + 1, exp_a, d);
      tick();
      ioctl_wr = 1'b0;
   endtask

   task automatic push_patch(input int first, input logic [15:0] end_addr);
      logic [15:0] pa [0:7];
      int n;
      pa = '{16'h002D, 16'h002E, 16'h002F, 16'h0030, 16'h0031, 16'h0032, 16'h00AE, 16'h00AF};
      for (int i = 0; i < 8; i++)
         push_wr(first + i * STEP, pa[i], (i % 2 == 1) ? end_addr[15:8] : end_addr[7:0]);
      n = 8;
`ifdef PRG_AUTORUN_EN
      push_wr(first + 8 * STEP,  16'h0527, 8'h52);
      push_wr(first + 9 * STEP,  16'h0528, 8'h55);
      push_wr(first + 10 * STEP, 16'h0529, 8'h4E);
      push_wr(first + 11 * STEP, 16'h052A, 8'h0D);
      push_wr(first + 12 * STEP, 16'h00EF, 8'h04);
      n = 13;
`endif
      exp_done_q.push_back(first + (n - 1) * STEP + 1);
   endtask

   task automatic drain(input string tag);
      ev_t e;
      ev_t o;
      int  ed;
      int  od;
      while (exp_q.size() > 0 || obs_q.size() > 0) begin
         if (exp_q.size() == 0) begin
            o = obs_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s_wr: got write @%0d %04h=%02h, want none", tag, o.cyc, o.a, o.d);
         end else if (obs_q.size() == 0) begin
            e = exp_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s_wr: got none, want write @%0d %04h=%02h", tag, e.cyc, e.a, e.d);
         end else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            chk({tag, "_wr_cycle"}, o.cyc, e.cyc);
            chk({tag, "_wr_addr"}, {16'd0, o.a}, {16'd0, e.a});
            chk({tag, "_wr_data"}, {24'd0, o.d}, {24'd0, e.d});
         end
      end
      while (exp_done_q.size() > 0 || obs_done_q.size() > 0) begin
         if (exp_done_q.size() == 0) begin
            od = obs_done_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s_load_done: got pulse @%0d, want none", tag, od);
         end else if (obs_done_q.size() == 0) begin
            ed = exp_done_q.pop_front();
            total++;
            bad++;
            $display("FAIL %s_load_done: got none, want pulse @%0d", tag, ed);
         end else begin
            ed = exp_done_q.pop_front();
            od = obs_done_q.pop_front();
            chk({tag, "_load_done_cycle"}, od, ed);
         end
      end
   endtask

   task automatic run_vec(input int n, input vec_t v);
      logic [15:0] a;
      logic [7:0]  d;
      bit          q;
      string       tag;
      tag = $sformatf("vec%0d", n);
      q   = (v.idx == 8'd1);
      a   = {v.bytes[71:64], v.bytes[79:72]};
      tick();
      ioctl_index    = v.idx;
      ioctl_download = 1'b1;
      for (int i = 0; i < int'(v.len); i++) begin
         d = v.bytes[79 - 8 * i -: 8];
         byte_io(i, d, q && i >= 2, a);
         if (q && i >= 2) a = a + 16'd1;
         chk({tag, "_busy_during"}, {31'd0, busy}, {31'd0, q});
         if (q && i == 0) chk({tag, "_err_cleared"}, {31'd0, err_short}, 32'd0);
      end
      tick();
      ioctl_download = 1'b0;
      if (v.exp_done) push_patch(cyc + 1, v.end_addr);
      repeat (40) tick();
      chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
      chk({tag, "_err_short"}, {31'd0, err_short}, {31'd0, v.exp_err});
      drain(tag);
      $display("vec%0d idx=%0d len=%0d checked, total=%0d", n, v.idx, v.len, total);
   endtask

   initial begin
      vec_t vecs [0:6];
      int   c;

      vecs[0] = {8'd1, 4'd5,  80'h0110AABBCC0000000000, 16'h1004, 1'b0, 1'b1};
      vecs[1] = {8'd1, 4'd4,  80'hFFFF1122000000000000, 16'h0001, 1'b0, 1'b1};
      vecs[2] = {8'd1, 4'd2,  80'h00200000000000000000, 16'h0000, 1'b1, 1'b0};
      vecs[3] = {8'd2, 4'd10, 80'h00112233445566778899, 16'h0000, 1'b1, 1'b0};
      vecs[4] = {8'd1, 4'd3,  80'h00C05A00000000000000, 16'hC001, 1'b0, 1'b1};
      vecs[5] = {8'd1, 4'd1,  80'h33000000000000000000, 16'h0000, 1'b1, 1'b0};
      vecs[6] = {8'd1, 4'd6,  80'h00400102030400000000, 16'h4004, 1'b0, 1'b1};

      reset = 1'b1;
      repeat (3) tick();
      chk("rst_dl_addr", {16'd0, dl_addr}, 32'd0);
      chk("rst_dl_data", {24'd0, dl_data}, 32'd0);
      chk("rst_dl_wr", {31'd0, dl_wr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_load_done", {31'd0, load_done}, 32'd0);
      chk("rst_err_short", {31'd0, err_short}, 32'd0);
      reset = 1'b0;
      tick();
      $display("reset state checked, total=%0d", total);

      for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

      // Last byte strobed on the same cycle the download window closes.
      tick();
      ioctl_index    = 8'd1;
      ioctl_download = 1'b1;
      byte_io(0, 8'h01, 1'b0, 16'h0000);
      byte_io(1, 8'h10, 1'b0, 16'h0000);
      tick();
      ioctl_wr       = 1'b1;
      ioctl_addr     = 25'd2;
      ioctl_dout     = 8'hAA;
      ioctl_download = 1'b0;
      c = cyc;
      push_wr(c + 1, 16'h1001, 8'hAA);
      push_patch(c + 2 + GAP, 16'h1002);
      tick();
      ioctl_wr = 1'b0;
      repeat (40) tick();
      chk("coinc_busy_end", {31'd0, busy}, 32'd0);
      drain("coinc");
      $display("coincident edge checked, total=%0d", total);

      // New download arriving mid-patch cuts the patch short.
      tick();
      ioctl_download = 1'b1;
      byte_io(0, 8'h01, 1'b0, 16'h0000);
      byte_io(1, 8'h10, 1'b0, 16'h0000);
      byte_io(2, 8'hAA, 1'b1, 16'h1001);
      tick();
      ioctl_download = 1'b0;
      c = cyc;
      push_wr(c + 1, 16'h002D, 8'h02);
      push_wr(c + 1 + STEP, 16'h002E, 8'h10);
      tick();
      tick();
      ioctl_download = 1'b1;
      byte_io(0, 8'h00, 1'b0, 16'h0000);
      chk("restart_busy", {31'd0, busy}, 32'd1);
      byte_io(1, 8'h30, 1'b0, 16'h0000);
      byte_io(2, 8'h77, 1'b1, 16'h3000);
      tick();
      ioctl_download = 1'b0;
      push_patch(cyc + 1, 16'h3001);
      repeat (40) tick();
      chk("restart_busy_end", {31'd0, busy}, 32'd0);
      drain("restart");
      $display("restart during patch checked, total=%0d", total);

      // Reset right after the third patch write.
      tick();
      ioctl_download = 1'b1;
      byte_io(0, 8'h01, 1'b0, 16'h0000);
      byte_io(1, 8'h10, 1'b0, 16'h0000);
      byte_io(2, 8'hAA, 1'b1, 16'h1001);
      tick();
      ioctl_download = 1'b0;
      c = cyc;
      push_wr(c + 1, 16'h002D, 8'h02);
      push_wr(c + 1 + STEP, 16'h002E, 8'h10);
      push_wr(c + 1 + 2 * STEP, 16'h002F, 8'h02);
      while (cyc < c + 1 + 2 * STEP) tick();
      reset = 1'b1;
      tick();
      chk("midrst_dl_wr", {31'd0, dl_wr}, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      repeat (40) tick();
      chk("midrst_busy_end", {31'd0, busy}, 32'd0);
      drain("midrst");
      $display("reset during patch checked, total=%0d", total);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
